// File: rtl/mouse_pkg.sv
// mouse_pkg: shared types and constants for the PS/2 mouse receive path.
//   rx_state_t          receiver FSM state encoding
//   RX_ERR_*            BYTE_ERROR_CODE values (bit0 parity, bit1 stop)
//   RX_TIMEOUT_DEFAULT  default inter-edge timeout (1 ms at 50 MHz)
package mouse_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    DONE   = 3'd4
  } rx_state_t;

  localparam logic [1:0] RX_ERR_NONE   = 2'b00;
  localparam logic [1:0] RX_ERR_PARITY = 2'b01;
  localparam logic [1:0] RX_ERR_STOP   = 2'b10;

  localparam int RX_TIMEOUT_DEFAULT = 50000;

endpackage

// File: rtl/ps2_mouse_receiver_if.sv
// ps2_mouse_receiver_if: receiver-control port between the PS/2 receiver and
// the mouse master FSM.
//   READ_ENABLE      master -> receiver, new frames may be accepted
//   BYTE_READ        receiver -> master, last data byte
//   BYTE_ERROR_CODE  receiver -> master, {stop_err, parity_err}
//   BYTE_READY       receiver -> master, one-cycle valid pulse
interface ps2_mouse_receiver_if;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;

  modport master (output READ_ENABLE, input  BYTE_READ, BYTE_ERROR_CODE, BYTE_READY);
  modport slave  (input  READ_ENABLE, output BYTE_READ, BYTE_ERROR_CODE, BYTE_READY);
endinterface

// File: rtl/ps2_mouse_receiver_sync.sv
// ps2_sync: 2-FF synchroniser for one PS/2 pad line plus falling-edge detect.
//   CLK, RESET  system clock, async active-low reset
//   din         raw pad input
//   level       synchronised (optionally filtered) level, resets to 1
//   falling     one-cycle pulse when level goes 1 -> 0
// Optional macro PS2_RX_FILTER_EN: level only follows the synchroniser after
// 8 consecutive samples that differ from the current level (8 cycles extra
// latency, short glitches rejected).
module ps2_sync (
  input  logic CLK,
  input  logic RESET,
  input  logic din,
  output logic level,
  output logic falling
);

  logic [1:0] ff;
  logic       prev;

  // Reset to the idle bus level so no edge is seen coming out of reset.
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) ff <= 2'b11;
    else        ff <= {ff[0], din};

`ifdef PS2_RX_FILTER_EN
  logic       filt;
  logic [2:0] cnt;

  // cnt counts consecutive samples disagreeing with filt; the 8th flips it.
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      filt <= 1'b1;
      cnt  <= 3'd0;
    end else if (ff[1] != filt) begin
      if (cnt == 3'd7) begin
        filt <= ff[1];
        cnt  <= 3'd0;
      end else begin
        cnt  <= cnt + 3'd1;
      end
    end else begin
      cnt <= 3'd0;
    end

  assign level = filt;
`else
  assign level = ff[1];
`endif

  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) prev <= 1'b1;
    else        prev <= level;

  assign falling = prev & ~level;

endmodule

// File: rtl/ps2_mouse_receiver.sv
// ps2_mouse_receiver: receives 11-bit PS/2 device-to-host frames and hands
// each data byte plus error code to the mouse master FSM.
//   CLK, RESET     system clock, async active-low reset
//   CLK_MOUSE_IN   raw PS/2 clock pad
//   DATA_MOUSE_IN  raw PS/2 data pad
//   rx             receiver-control port (slave side)
// Parameters: TIMEOUT_CYCLES max cycles between clock falls in a frame,
// TIMEOUT_W counter width.
// Optional macro PS2_RX_FILTER_EN: glitch filter on both synchronised lines.
module ps2_mouse_receiver
  import mouse_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = RX_TIMEOUT_DEFAULT,
  parameter int TIMEOUT_W      = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 CLK_MOUSE_IN,
  input  logic                 DATA_MOUSE_IN,
  ps2_mouse_receiver_if.slave  rx
);

  logic clk_lvl, clk_fall;
  logic data_lvl, data_fall;

  ps2_sync u_sync_clk (
    .CLK(CLK), .RESET(RESET), .din(CLK_MOUSE_IN),
    .level(clk_lvl), .falling(clk_fall)
  );

  // Same path as the clock so data stays aligned with the edge pulse.
  ps2_sync u_sync_data (
    .CLK(CLK), .RESET(RESET), .din(DATA_MOUSE_IN),
    .level(data_lvl), .falling(data_fall)
  );

  rx_state_t            state, state_n;
  logic [2:0]           bit_cnt;
  logic [7:0]           shift;
  logic                 parity_err, stop_err;
  logic [TIMEOUT_W-1:0] tmo;
  logic                 in_frame, tmo_hit;

  assign in_frame = (state == DATA) || (state == PARITY) || (state == STOP);
  assign tmo_hit  = in_frame && (tmo == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) state <= IDLE;
    else        state <= state_n;

  // A stalled frame is abandoned silently; timeout wins over a coincident edge.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (clk_fall && rx.READ_ENABLE && !data_lvl) state_n = DATA;
      DATA:   if (tmo_hit) state_n = IDLE;
              else if (clk_fall && bit_cnt == 3'd7) state_n = PARITY;
      PARITY: if (tmo_hit) state_n = IDLE;
              else if (clk_fall) state_n = STOP;
      STOP:   if (tmo_hit) state_n = IDLE;
              else if (clk_fall) state_n = DONE;
      DONE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      bit_cnt            <= 3'd0;
      shift              <= 8'h00;
      parity_err         <= 1'b0;
      stop_err           <= 1'b0;
      tmo                <= '0;
      rx.BYTE_READ       <= 8'h00;
      rx.BYTE_ERROR_CODE <= RX_ERR_NONE;
      rx.BYTE_READY      <= 1'b0;
    end else begin
      rx.BYTE_READY <= 1'b0;
      tmo <= (!in_frame || clk_fall) ? '0 : tmo + 1'b1;
      case (state)
        IDLE:   bit_cnt <= 3'd0;
        DATA:   if (clk_fall) begin
                  shift   <= {data_lvl, shift[7:1]};  // LSB first on the wire
                  bit_cnt <= bit_cnt + 3'd1;
                end
        PARITY: if (clk_fall) parity_err <= ~^{shift, data_lvl};
        STOP:   if (clk_fall) stop_err <= ~data_lvl;
        DONE: begin
          rx.BYTE_READ       <= shift;
          rx.BYTE_ERROR_CODE <= {stop_err, parity_err};
          rx.BYTE_READY      <= 1'b1;
        end
        default: ;
      endcase
    end

endmodule

// File: tb/tb_ps2_mouse_receiver.sv
// tb_ps2_mouse_receiver: drives PS/2 frames onto the pads; a frame that should
// be delivered pushes {byte, code, due cycle} into a queue, and an independent
// monitor pops on every BYTE_READY and compares. Between pulses the monitor
// checks that the outputs hold. Define PS2_RX_FILTER_EN to exercise the filter.
module tb_ps2_mouse_receiver;
  import mouse_pkg::*;

  localparam int TMO  = 300;
  localparam int HALF = 40;
`ifdef PS2_RX_FILTER_EN
  localparam int LAT = 12;
`else
  localparam int LAT = 4;
`endif

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic ps2c = 1'b1;
  logic ps2d = 1'b1;

  ps2_mouse_receiver_if bus ();

  ps2_mouse_receiver #(.TIMEOUT_CYCLES(TMO), .TIMEOUT_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .CLK_MOUSE_IN(ps2c), .DATA_MOUSE_IN(ps2d), .rx(bus)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    logic [1:0] code;
    int         at;
  } exp_t;

  exp_t q[$];
  exp_t pend;
  bit   pend_v = 0;
  int   vectors = 0;
  int   miscompares = 0;

  // Reference: odd parity over data+parity bit, stop bit must be 1.
  function automatic logic [1:0] ref_code(input logic [7:0] b, input logic par, input logic stp);
    logic perr, serr;
    perr = ($countones({b, par}) % 2) == 0;
    serr = (stp == 1'b0);
    return {serr, perr};
  endfunction

  // Monitor / scoreboard
  initial begin
    exp_t e;
    logic [7:0] last_b = 8'h00;
    logic [1:0] last_c = 2'b00;
    forever begin
      @(posedge CLK); #1;
      if (!RESET) begin
        vectors++;
        if (bus.BYTE_READY !== 1'b0 || bus.BYTE_READ !== 8'h00 || bus.BYTE_ERROR_CODE !== 2'b00) begin
          miscompares++;
          $display("FAIL reset_outputs: got rdy=%b byte=%h code=%b, want 0/00/00",
                   bus.BYTE_READY, bus.BYTE_READ, bus.BYTE_ERROR_CODE);
        end
        last_b = 8'h00; last_c = 2'b00;
      end else if (bus.BYTE_READY === 1'b1) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_ready: got byte=%h code=%b at cyc %0d, want no pulse",
                   bus.BYTE_READ, bus.BYTE_ERROR_CODE, cyc);
        end else begin
          e = q.pop_front();
          if (bus.BYTE_READ !== e.b || bus.BYTE_ERROR_CODE !== e.code || cyc != e.at) begin
            miscompares++;
            $display("FAIL frame: got byte=%h code=%b cyc=%0d, want byte=%h code=%b cyc=%0d",
                     bus.BYTE_READ, bus.BYTE_ERROR_CODE, cyc, e.b, e.code, e.at);
          end
          last_b = e.b; last_c = e.code;
        end
      end else if (bus.BYTE_READ !== last_b || bus.BYTE_ERROR_CODE !== last_c) begin
        miscompares++;
        $display("FAIL hold: got byte=%h code=%b, want byte=%h code=%b",
                 bus.BYTE_READ, bus.BYTE_ERROR_CODE, last_b, last_c);
      end
    end
  end

  // One PS/2 bit: data changes while clock high, then a low half-period.
  task automatic ps2_bit(input logic v);
    @(negedge CLK); ps2d = v;
    repeat (HALF - 1) @(negedge CLK);
    ps2c = 1'b0;
    if (pend_v) begin
      pend.at = cyc + LAT;
      q.push_back(pend);
      pend_v = 0;
    end
    repeat (HALF) @(negedge CLK);
    ps2c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                            input logic re_start, input bit drop_re);
    bus.READ_ENABLE = re_start;
    ps2_bit(1'b0);
    if (drop_re) bus.READ_ENABLE = 1'b0;
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    if (re_start) begin
      pend.b = b; pend.code = ref_code(b, par, stp); pend.at = 0;
      pend_v = 1;
    end
    ps2_bit(stp);
    @(negedge CLK); ps2d = 1'b1; bus.READ_ENABLE = 1'b1;
    repeat (2 * HALF) @(negedge CLK);
  endtask

  task automatic check_state(input string name, input bit want_idle);
    vectors++;
    if ((dut.state == IDLE) != want_idle) begin
      miscompares++;
      $display("FAIL %s: got state=%0d, want %s", name, dut.state, want_idle ? "IDLE" : "not IDLE");
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic par, stp, re;
    bit drop;
    bus.READ_ENABLE = 1'b1;
    repeat (5) @(negedge CLK);
    RESET = 1'b1;
    repeat (20) @(negedge CLK);

    send_frame(8'hFA, 1'b1, 1'b1, 1'b1, 0);    // good
    send_frame(8'h08, 1'b1, 1'b1, 1'b1, 0);    // parity error
    send_frame(8'h00, 1'b1, 1'b0, 1'b1, 0);    // stop error
    send_frame(8'hF4, 1'b0, 1'b1, 1'b0, 0);    // ignored, READ_ENABLE low

    // Stall after 4 data bits; must time out and then receive cleanly.
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (TMO + 20) @(negedge CLK);
    check_state("timeout_idle", 1);
    ps2d = 1'b1;
    send_frame(8'h55, 1'b1, 1'b1, 1'b1, 0);

    // Reset mid-frame after 5 bits of 0xAA.
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(i[0]);
    @(negedge CLK); RESET = 1'b0;
    repeat (6) @(negedge CLK);
    ps2c = 1'b1; ps2d = 1'b1;
    RESET = 1'b1;
    repeat (20) @(negedge CLK);
    send_frame(8'h12, 1'b1, 1'b1, 1'b1, 0);

    // One-cycle clock glitch in IDLE with data low.
    ps2d = 1'b0;
    repeat (HALF) @(negedge CLK);
    ps2c = 1'b0;
    @(negedge CLK); ps2c = 1'b1;
    repeat (20) @(negedge CLK);
`ifdef PS2_RX_FILTER_EN
    check_state("glitch_filtered", 1);
`else
    check_state("glitch_start", 0);
`endif
    ps2d = 1'b1;
    repeat (TMO + 50) @(negedge CLK);
    check_state("glitch_recover", 1);

    // Random frames: occasional bad parity/stop, disabled or dropped READ_ENABLE.
    for (int n = 0; n < 25; n++) begin
      b    = 8'($urandom);
      par  = ~^b;
      if ($urandom_range(0, 4) == 0) par = ~par;
      stp  = ($urandom_range(0, 6) != 0);
      re   = ($urandom_range(0, 9) != 0);
      drop = ($urandom_range(0, 2) == 0);
      send_frame(b, par, stp, re, drop);
    end

    for (int k = 0; k < 1000 && q.size() != 0; k++) @(negedge CLK);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending frames, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_receiver.md
# ps2_mouse_receiver

Receives 11-bit PS/2 device-to-host frames from the mouse and delivers each data byte with an error code to the mouse master state machine. Sits between the PS/2 pads (clock/data inputs) and the master FSM's receiver-control port (READ_ENABLE / BYTE_READ / BYTE_ERROR_CODE / BYTE_READY). Handles synchronisation, falling-edge sampling, odd-parity and stop-bit checking, and frame timeout recovery.

## Interface
- TIMEOUT_CYCLES, 50000: max CLK cycles between PS/2 clock falling edges inside a frame (1 ms at 50 MHz).
- TIMEOUT_W, 16: width of timeout counter; must hold TIMEOUT_CYCLES.
- CLK  in  1  system clock.
- RESET  in  1  reset, asynchronous, active-low.
- CLK_MOUSE_IN  in  1  raw PS/2 clock from pad.
- DATA_MOUSE_IN  in  1  raw PS/2 data from pad.
- READ_ENABLE  in  1  high: new frames may be accepted.
- BYTE_READ  out  8  last received data byte, LSB = first data bit.
- BYTE_ERROR_CODE  out  2  bit0 parity error, bit1 stop-bit error; 2'b00 = good.
- BYTE_READY  out  1  one-cycle pulse, BYTE_READ/BYTE_ERROR_CODE valid.

## Operation
- Both pad inputs pass through 2-FF synchronisers; clk_prev register gives falling = clk_prev & ~clk_sync. All sampling uses the synchronised data at the falling-edge cycle.
- States: IDLE, DATA, PARITY, STOP, DONE.
- IDLE: on falling edge with READ_ENABLE=1 and data=0 (start bit) -> DATA, bit_cnt=0, timeout cleared. Start bit 1 -> stay IDLE. READ_ENABLE=0 -> edges ignored.
- DATA: each falling edge shifts data into shift[7:0] from MSB side (LSB first on wire); after 8th bit -> PARITY.
- PARITY: sample parity bit; parity_err = ~^{shift, bit} (odd parity required) -> STOP.
- STOP: sample stop bit; stop_err = ~bit -> DONE.
- DONE: one cycle; BYTE_READ<=shift, BYTE_ERROR_CODE<={stop_err,parity_err}, BYTE_READY=1 -> IDLE.
- READ_ENABLE sampled only in IDLE; deassertion mid-frame does not abort the frame.
- Timeout: in DATA/PARITY/STOP, counter increments each cycle, cleared on each falling edge; reaching TIMEOUT_CYCLES-1 -> IDLE, no BYTE_READY, outputs unchanged.
- Errored frames still pulse BYTE_READY with nonzero code; consumer decides.
- Reset (any time, including mid-frame): state IDLE, BYTE_READ=8'h00, BYTE_ERROR_CODE=2'b00, BYTE_READY=0, shift/counters 0, synchronisers to 1 (idle bus level).

## Timing
- Pad falling edge visible as falling pulse 2 CLK cycles after first CLK edge sampling low (3rd edge).
- BYTE_READY asserted exactly 2 CLK cycles after the stop-bit falling pulse (STOP->DONE register, DONE output register); high for exactly 1 cycle.
- BYTE_READ/BYTE_ERROR_CODE change only in the BYTE_READY cycle, then hold until next frame completes.
- Earliest next start bit accepted the cycle after DONE.
- PS/2 clock 10-16.7 kHz; CLK >= 1 MHz required for the synchroniser to see every edge.

## Configuration
- PS2_RX_FILTER_EN defined: clock synchroniser output passes a glitch filter; level changes only after 8 consecutive equal synchronised samples; adds 8 cycles latency to both clock and data (data delayed equally to stay aligned). Timing numbers above increase by 8.
- Undefined: plain 2-FF synchroniser, no filter; a one-cycle clock glitch produces a spurious edge.

## Structure
- Shared package mouse_pkg: state enum rx_state_t, error constants RX_ERR_NONE=2'b00, RX_ERR_PARITY=2'b01, RX_ERR_STOP=2'b10, default TIMEOUT_CYCLES value.
- One sub-module ps2_sync: synchroniser + optional filter + falling-edge detect, instantiated for the clock line; data line uses same module with edge output unused.

## Test plan
- Frame 0xFA, parity 1, stop 1, READ_ENABLE=1 -> one BYTE_READY pulse, BYTE_READ=8'hFA, BYTE_ERROR_CODE=2'b00.
- Frame 0x08 with parity 1 (wrong, should be 0) -> BYTE_READ=8'h08, code 2'b01; next frame 0x00 stop=0, parity 1 -> code 2'b10.
- READ_ENABLE=0, full frame 0xF4 sent -> no BYTE_READY, BYTE_READ stays at previous value.
- 4 data bits then clock held high for TIMEOUT_CYCLES -> back to IDLE, no pulse; following frame 0x55 received correctly, code 2'b00.
- RESET low after 5 bits of frame 0xAA, release, send 0x12 -> only 0x12 reported; all outputs 0 during reset.
- With PS2_RX_FILTER_EN: 1-cycle low glitch on clock in IDLE with data low -> no start detected; without macro -> frame begins (bench checks state leaves IDLE).
